// File: rtl/dcache_arb2_pkg.sv
// Shared encodings for the data-side DCache port arbiter: FSM states,
// DCache op codes and the access-size codes used by the memory unit.
package dcache_arb2_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic DC_OP_READ  = 1'b0;
    localparam logic DC_OP_WRITE = 1'b1;

    localparam logic [3:0] MEM_BYTES_1 = 4'h1;
    localparam logic [3:0] MEM_BYTES_2 = 4'h2;
    localparam logic [3:0] MEM_BYTES_4 = 4'h4;
    localparam logic [3:0] MEM_BYTES_8 = 4'h8;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// a tie goes to the requester named by pointer.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = (&req) ? pointer : req[1];

endmodule

// File: rtl/dcache_arb2.sv
// Two-requester arbiter in front of the single DCache port. Grants are
// round-robin, held for the whole req/ack transaction, command registered.
module dcache_arb2
    import dcache_arb2_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic              i_m0_op,
    input  logic [3:0]        i_m0_bytes,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,

    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic              i_m1_op,
    input  logic [3:0]        i_m1_bytes,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,

    output logic              o_dcache_req,
    output logic [ADDR_W-1:0] o_dcache_addr,
    output logic              o_dcache_op,
    output logic [3:0]        o_dcache_bytes,
    output logic [DATA_W-1:0] o_dcache_wdata,
    input  logic              i_dcache_ack,
    input  logic [DATA_W-1:0] i_dcache_rdata,

    output logic              o_busy,
    output logic              o_grant
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       rr_ptr;
    logic       pick_valid;
    logic       pick_winner;
    logic       load;
    logic       done;
    logic       ack_live;

    arb_rr2 u_pick (
        .req     ({i_m1_req, i_m0_req}),
        .pointer (rr_ptr),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would make synthesis infer a latch.
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ARB_BUSY;
                    load      = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (i_dcache_ack) begin
                    state_nxt = ARB_IDLE;
                    done      = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the command registers are reset too, so the DCache bus
            // never carries X even though it is only qualified by o_dcache_req.
            o_dcache_req   <= 1'b0;
            o_dcache_addr  <= '0;
            o_dcache_op    <= DC_OP_READ;
            o_dcache_bytes <= '0;
            o_dcache_wdata <= '0;
            o_grant        <= 1'b0;
            rr_ptr         <= 1'b0;
        end else if (load) begin
            o_dcache_req   <= 1'b1;
            o_grant        <= pick_winner;
            o_dcache_addr  <= pick_winner ? i_m1_addr  : i_m0_addr;
            o_dcache_op    <= pick_winner ? i_m1_op    : i_m0_op;
            o_dcache_bytes <= pick_winner ? i_m1_bytes : i_m0_bytes;
            o_dcache_wdata <= pick_winner ? i_m1_wdata : i_m0_wdata;
        end else if (done) begin
            o_dcache_req   <= 1'b0;
            rr_ptr         <= ~o_grant;
        end
    end

    // Completion is only meaningful while a transaction is in flight.
    assign ack_live   = (state == ARB_BUSY) && i_dcache_ack;
    assign o_m0_ack   = ack_live && !o_grant;
    assign o_m1_ack   = ack_live &&  o_grant;
    assign o_m0_rdata = o_m0_ack ? i_dcache_rdata : '0;
    assign o_m1_rdata = o_m1_ack ? i_dcache_rdata : '0;
    assign o_busy     = (state == ARB_BUSY);

endmodule

// File: tb/tb_dcache_arb2.sv
// Directed bench for dcache_arb2: a per-cycle vector table followed by
// hand-written multi-cycle sequences (fairness, freeze, reset abort, latency).
module tb_dcache_arb2;
    import dcache_arb2_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_op, m1_op;
    logic [63:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_bytes, m1_bytes;
    logic        m0_ack, m1_ack;
    logic [63:0] m0_rdata, m1_rdata;
    logic        dc_req, dc_op, dc_ack;
    logic [63:0] dc_addr, dc_wdata, dc_rdata;
    logic [3:0]  dc_bytes;
    logic        busy, grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcache_arb2 dut (
        .clk            (clk),
        .rst            (rst),
        .i_m0_req       (m0_req),
        .i_m0_addr      (m0_addr),
        .i_m0_op        (m0_op),
        .i_m0_bytes     (m0_bytes),
        .i_m0_wdata     (m0_wdata),
        .o_m0_ack       (m0_ack),
        .o_m0_rdata     (m0_rdata),
        .i_m1_req       (m1_req),
        .i_m1_addr      (m1_addr),
        .i_m1_op        (m1_op),
        .i_m1_bytes     (m1_bytes),
        .i_m1_wdata     (m1_wdata),
        .o_m1_ack       (m1_ack),
        .o_m1_rdata     (m1_rdata),
        .o_dcache_req   (dc_req),
        .o_dcache_addr  (dc_addr),
        .o_dcache_op    (dc_op),
        .o_dcache_bytes (dc_bytes),
        .o_dcache_wdata (dc_wdata),
        .i_dcache_ack   (dc_ack),
        .i_dcache_rdata (dc_rdata),
        .o_busy         (busy),
        .o_grant        (grant)
    );

    typedef struct {
        logic        m0r;
        logic [63:0] m0a;
        logic        m0op;
        logic        m1r;
        logic [63:0] m1a;
        logic        m1op;
        logic        ack;
        logic [63:0] rd;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_op;
        logic [3:0]  e_bytes;
        logic        e_grant;
        logic        e_ack0;
        logic [63:0] e_rd0;
        logic        e_ack1;
        logic [63:0] e_rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m1_req = 1'b0; dc_ack = 1'b0; dc_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_g;
        logic stable;

        rst = 1'b1;
        clear_inputs();
        m0_addr = '0; m1_addr = '0; m0_op = DC_OP_READ; m1_op = DC_OP_READ;
        m0_wdata = 64'hA0; m1_wdata = 64'hB0;
        m0_bytes = MEM_BYTES_8; m1_bytes = MEM_BYTES_4;

        //        m0r m0a            m0op         m1r m1a      m1op        ack rd
        //        e_req e_addr         e_op         e_bytes      g  ack0 rd0  ack1 rd1
        vecs.push_back('{1, 64'h8000_0010, DC_OP_READ,  0, 64'h0,   DC_OP_READ, 0, 64'h0,
                         0, 64'h0,         DC_OP_READ,  4'h0,        0, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h8000_0010, DC_OP_READ,  0, 64'h0,   DC_OP_READ, 0, 64'h0,
                         1, 64'h8000_0010, DC_OP_READ,  MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h8000_0010, DC_OP_READ,  0, 64'h0,   DC_OP_READ, 0, 64'h0,
                         1, 64'h8000_0010, DC_OP_READ,  MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h8000_0010, DC_OP_READ,  0, 64'h0,   DC_OP_READ, 0, 64'h0,
                         1, 64'h8000_0010, DC_OP_READ,  MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h8000_0010, DC_OP_READ,  0, 64'h0,   DC_OP_READ, 1, 64'hDEAD_BEEF_0123_4567,
                         1, 64'h8000_0010, DC_OP_READ,  MEM_BYTES_8, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 64'h0});
        vecs.push_back('{0, 64'h0,         DC_OP_READ,  0, 64'h0,   DC_OP_READ, 0, 64'h0,
                         0, 64'h8000_0010, DC_OP_READ,  MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});
        // Spurious ack in IDLE: nothing acked, pointer (now 1) untouched.
        vecs.push_back('{0, 64'h0,         DC_OP_READ,  0, 64'h0,   DC_OP_READ, 1, 64'h5555,
                         0, 64'h8000_0010, DC_OP_READ,  MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h300,       DC_OP_WRITE, 1, 64'h400, DC_OP_READ, 0, 64'h0,
                         0, 64'h8000_0010, DC_OP_READ,  MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h300,       DC_OP_WRITE, 1, 64'h400, DC_OP_READ, 0, 64'h0,
                         1, 64'h400,       DC_OP_READ,  MEM_BYTES_4, 1, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h300,       DC_OP_WRITE, 1, 64'h400, DC_OP_READ, 1, 64'h1111,
                         1, 64'h400,       DC_OP_READ,  MEM_BYTES_4, 1, 0, 64'h0, 1, 64'h1111});
        vecs.push_back('{1, 64'h300,       DC_OP_WRITE, 0, 64'h400, DC_OP_READ, 0, 64'h0,
                         0, 64'h400,       DC_OP_READ,  MEM_BYTES_4, 1, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h300,       DC_OP_WRITE, 0, 64'h0,   DC_OP_READ, 0, 64'h0,
                         1, 64'h300,       DC_OP_WRITE, MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h300,       DC_OP_WRITE, 0, 64'h0,   DC_OP_READ, 1, 64'h2222,
                         1, 64'h300,       DC_OP_WRITE, MEM_BYTES_8, 0, 1, 64'h2222, 0, 64'h0});
        vecs.push_back('{0, 64'h0,         DC_OP_READ,  0, 64'h0,   DC_OP_READ, 0, 64'h0,
                         0, 64'h300,       DC_OP_WRITE, MEM_BYTES_8, 0, 0, 64'h0, 0, 64'h0});

        // Reset state, with a stray DCache ack present.
        dc_ack = 1'b1;
        #12;
        check("rst_dc_req", dc_req, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_addr", dc_addr, 0);
        check("rst_m0_ack", m0_ack, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        dc_ack = 1'b0;
        #1;
        rst = 1'b0;
        next_cycle();

        foreach (vecs[i]) begin
            m0_req = vecs[i].m0r; m0_addr = vecs[i].m0a; m0_op = vecs[i].m0op;
            m1_req = vecs[i].m1r; m1_addr = vecs[i].m1a; m1_op = vecs[i].m1op;
            dc_ack = vecs[i].ack; dc_rdata = vecs[i].rd;
            @(negedge clk);
            check($sformatf("v%0d_dc_req", i), dc_req, vecs[i].e_req);
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_req);
            check($sformatf("v%0d_addr", i), dc_addr, vecs[i].e_addr);
            check($sformatf("v%0d_op", i), dc_op, vecs[i].e_op);
            check($sformatf("v%0d_bytes", i), dc_bytes, vecs[i].e_bytes);
            check($sformatf("v%0d_grant", i), grant, vecs[i].e_grant);
            check($sformatf("v%0d_m0_ack", i), m0_ack, vecs[i].e_ack0);
            check($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].e_rd0);
            check($sformatf("v%0d_m1_ack", i), m1_ack, vecs[i].e_ack1);
            check($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].e_rd1);
            next_cycle();
        end
        clear_inputs();

        // Contention after reset: m0 first, then strict alternation.
        do_reset();
        m0_req = 1'b1; m0_addr = 64'h100; m0_op = DC_OP_WRITE; m0_bytes = MEM_BYTES_8;
        m1_req = 1'b1; m1_addr = 64'h200; m1_op = DC_OP_READ;  m1_bytes = MEM_BYTES_4;
        for (int t = 0; t < 8; t++) begin
            exp_g = t[0];
            @(negedge clk);
            check($sformatf("alt%0d_idle", t), busy, 0);
            next_cycle();
            dc_ack = 1'b1; dc_rdata = 64'h1000 + 64'(t);
            @(negedge clk);
            check($sformatf("alt%0d_grant", t), grant, exp_g);
            check($sformatf("alt%0d_addr", t), dc_addr, exp_g ? 64'h200 : 64'h100);
            check($sformatf("alt%0d_op", t), dc_op, exp_g ? DC_OP_READ : DC_OP_WRITE);
            check($sformatf("alt%0d_m0_ack", t), m0_ack, !exp_g);
            check($sformatf("alt%0d_m1_ack", t), m1_ack, exp_g);
            check($sformatf("alt%0d_rdata", t), exp_g ? m1_rdata : m0_rdata, 64'h1000 + 64'(t));
            check($sformatf("alt%0d_other_rdata", t), exp_g ? m0_rdata : m1_rdata, 0);
            next_cycle();
            dc_ack = 1'b0;
            m0_req = (t != 0);
        end
        clear_inputs();

        // Inputs changing during BUSY must not reach the DCache command.
        m0_req = 1'b1; m0_addr = 64'h40; m0_wdata = 64'hAAAA; m0_op = DC_OP_WRITE; m0_bytes = MEM_BYTES_1;
        @(negedge clk);
        check("frz_idle", busy, 0);
        next_cycle();
        m0_addr = 64'h80; m0_wdata = 64'hBBBB; m0_bytes = MEM_BYTES_8;
        m1_req = 1'b1; m1_addr = 64'h999; m1_wdata = 64'h9999;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("frz%0d_addr", k), dc_addr, 64'h40);
            check($sformatf("frz%0d_wdata", k), dc_wdata, 64'hAAAA);
            check($sformatf("frz%0d_bytes", k), dc_bytes, MEM_BYTES_1);
            check($sformatf("frz%0d_grant", k), grant, 0);
            next_cycle();
        end
        dc_ack = 1'b1; dc_rdata = 64'h0;
        @(negedge clk);
        check("frz_m0_ack", m0_ack, 1);
        check("frz_m1_ack", m1_ack, 0);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Asynchronous reset while BUSY aborts the transaction.
        m1_req = 1'b1; m1_addr = 64'h777;
        next_cycle();
        @(negedge clk);
        check("abort_busy_before", dc_req, 1);
        check("abort_grant_before", grant, 1);
        #2;
        rst = 1'b1; dc_ack = 1'b1; dc_rdata = 64'hFFFF;
        #1;
        check("abort_dc_req", dc_req, 0);
        check("abort_busy", busy, 0);
        check("abort_m1_ack", m1_ack, 0);
        check("abort_m1_rdata", m1_rdata, 0);
        check("abort_grant", grant, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        clear_inputs();
        m0_req = 1'b1; m0_addr = 64'h10;
        m1_req = 1'b1; m1_addr = 64'h20;
        next_cycle();
        @(negedge clk);
        check("post_rst_grant", grant, 0);
        check("post_rst_addr", dc_addr, 64'h10);
        dc_ack = 1'b1; dc_rdata = 64'h3C;
        #1;
        check("post_rst_m0_rdata", m0_rdata, 64'h3C);
        check("post_rst_m1_ack", m1_ack, 0);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Long DCache latency; m1 arrives meanwhile and must wait.
        m0_req = 1'b1; m0_addr = 64'h5000; m0_op = DC_OP_READ; m0_bytes = MEM_BYTES_2;
        next_cycle();
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin
                m1_req = 1'b1; m1_addr = 64'h6000; m1_bytes = MEM_BYTES_4;
            end
            @(negedge clk);
            stable = dc_req && busy && (dc_addr == 64'h5000) && (dc_bytes == MEM_BYTES_2)
                     && !grant && !m0_ack && !m1_ack;
            check($sformatf("lat%0d_stable", c), stable, 1);
            next_cycle();
        end
        dc_ack = 1'b1; dc_rdata = 64'hCAFE;
        @(negedge clk);
        check("lat_m0_ack", m0_ack, 1);
        check("lat_m0_rdata", m0_rdata, 64'hCAFE);
        check("lat_m1_ack", m1_ack, 0);
        next_cycle();
        dc_ack = 1'b0; m0_req = 1'b0;
        @(negedge clk);
        check("lat_turnaround_idle", busy, 0);
        next_cycle();
        @(negedge clk);
        check("lat_m1_busy", busy, 1);
        check("lat_m1_grant", grant, 1);
        check("lat_m1_addr", dc_addr, 64'h6000);
        dc_ack = 1'b1; dc_rdata = 64'hBEEF;
        #1;
        check("lat_m1_rdata", m1_rdata, 64'hBEEF);
        next_cycle();
        clear_inputs();
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
